// File: rtl/npu_pkg.sv
// Shared NPU types and constants: fetch FSM states and SDRAM beat geometry.
package npu_pkg;

    localparam int SDRAM_W    = 128;
    localparam int BEAT_BYTES = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; flush wins over push/pop.
module sync_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_en, pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_en  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign count   = count_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_en && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction prefetcher: issues SDRAM bursts only when the FIFO can absorb them
// whole, and streams the returned 128-bit words to the decoder.
module instr_fetch_unit
    import npu_pkg::*;
#(
    parameter int DATA_W     = SDRAM_W,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 8,
    parameter int BURST      = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  n_words,
    output logic              read_start,
    output logic [ADDR_W-1:0] read_addr,
    output logic [CNT_W-1:0]  read_cnt,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_valid,
    input  logic              read_done,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q;
    logic [LEN_W-1:0]  remaining_q, len;
    logic [ADDR_W-1:0] next_addr_q, read_addr_q;
    logic [CNT_W-1:0]  read_cnt_q;
    logic [CW-1:0]     reserved_q, fifo_count, free_slots;
    logic              read_start_q, done_q, busy_q;
    logic              push, pop, fifo_full, fifo_empty, can_issue;

    assign len        = (remaining_q > LEN_W'(BURST)) ? LEN_W'(BURST) : remaining_q;
    // Slots promised to the in-flight burst are not free even before data lands.
    assign free_slots = CW'(FIFO_DEPTH) - fifo_count - reserved_q;
    assign can_issue  = (32'(free_slots) >= 32'(len));

    assign push        = (state_q == WAIT) && read_valid;
    assign pop         = !fifo_empty && instr_ready;
    assign instr_valid = !fifo_empty;
    assign read_start  = read_start_q;
    assign read_addr   = read_addr_q;
    assign read_cnt    = read_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (read_data),
        .pop   (pop),
        .flush (abort),
        .rdata (instr),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            next_addr_q  <= '0;
            reserved_q   <= '0;
            read_start_q <= 1'b0;
            read_addr_q  <= '0;
            read_cnt_q   <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            read_start_q <= 1'b0;
            done_q       <= 1'b0;
            if (push) reserved_q <= reserved_q - CW'(1);
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (n_words == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            remaining_q <= n_words;
                            next_addr_q <= base_addr;
                            busy_q      <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        remaining_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (can_issue) begin
                        read_start_q <= 1'b1;
                        read_addr_q  <= next_addr_q;
                        read_cnt_q   <= CNT_W'(len);
                        next_addr_q  <= next_addr_q + ADDR_W'(len) * ADDR_W'(BEAT_BYTES);
                        remaining_q  <= remaining_q - len;
                        reserved_q   <= CW'(len);
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        remaining_q <= '0;
                        reserved_q  <= '0;
                        if (read_done) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (read_done) begin
                        if (remaining_q == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (read_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an SDRAM reader model and an
// address-based reference for the expected word stream and burst list.
module tb_instr_fetch_unit;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;
    localparam int BURST  = 8;
    localparam int DEPTH  = 32;
    localparam int LEN_W  = 16;

    logic              clk;
    logic              rst_n, start, abort;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  n_words;
    logic              read_start;
    logic [ADDR_W-1:0] read_addr;
    logic [CNT_W-1:0]  read_cnt;
    logic [DATA_W-1:0] read_data;
    logic              read_valid, read_done;
    logic [DATA_W-1:0] instr;
    logic              instr_valid, instr_ready, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;

    logic [DATA_W-1:0] out_q [$];
    logic [ADDR_W-1:0] iss_a [$];
    int                iss_c [$];
    int done_cnt = 0, busy_cyc = 0, beats_sent = 0, pulse_err = 0, hold_err = 0;

    logic [DATA_W-1:0] exp_w [$];
    logic [ADDR_W-1:0] exp_a [$];
    int                exp_c [$];

    instr_fetch_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BURST(BURST),
        .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .n_words(n_words),
        .read_start(read_start), .read_addr(read_addr), .read_cnt(read_cnt),
        .read_data(read_data), .read_valid(read_valid), .read_done(read_done),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] beat_of(input logic [ADDR_W-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1234};
    endfunction

    // SDRAM reader: one burst at a time, random beat gaps, read_done after the last beat.
    initial begin
        int                m_left;
        logic [ADDR_W-1:0] m_addr;
        bit                m_act;
        m_left = 0; m_addr = '0; m_act = 1'b0;
        read_valid = 1'b0; read_done = 1'b0; read_data = '0; instr_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            read_valid = 1'b0;
            read_done  = 1'b0;
            case (ready_mode)
                0:       instr_ready = 1'b0;
                1:       instr_ready = 1'b1;
                default: instr_ready = 1'($urandom_range(0, 1));
            endcase
            if (!rst_n) begin
                m_act = 1'b0;
            end else if (m_act) begin
                if (m_left == 0) begin
                    read_done = 1'b1;
                    m_act     = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    read_valid = 1'b1;
                    read_data  = beat_of(m_addr);
                    m_addr     = m_addr + 32'd16;
                    m_left--;
                    beats_sent++;
                end
            end else if (read_start) begin
                m_act  = 1'b1;
                m_left = int'(read_cnt);
                m_addr = read_addr;
            end
        end
    end

    // Observer: records issued bursts, consumed words and pulses on the falling edge.
    initial begin
        bit prev_rs;
        prev_rs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (read_start && prev_rs) pulse_err++;
                if (read_start) begin
                    iss_a.push_back(read_addr);
                    iss_c.push_back(int'(read_cnt));
                end
                if (read_valid && iss_a.size() > 0 && read_addr !== iss_a[iss_a.size()-1]) hold_err++;
                if (instr_valid && instr_ready) out_q.push_back(instr);
                if (done) done_cnt++;
                if (busy) busy_cyc++;
                prev_rs = read_start;
            end else begin
                prev_rs = 1'b0;
            end
        end
    end

    task automatic model_fetch(input logic [ADDR_W-1:0] base, input int n);
        int rem;
        int len;
        logic [ADDR_W-1:0] a;
        rem = n; a = base;
        exp_w.delete(); exp_a.delete(); exp_c.delete();
        for (int i = 0; i < n; i++) exp_w.push_back(beat_of(base + ADDR_W'(i) * 32'd16));
        while (rem > 0) begin
            len = (rem < BURST) ? rem : BURST;
            exp_a.push_back(a);
            exp_c.push_back(len);
            a   = a + ADDR_W'(len * 16);
            rem = rem - len;
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input int n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; n_words = LEN_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_fetch(input int o0, input int n, input int d0, output bit to);
        int cyc;
        cyc = 0;
        while ((done_cnt == d0 || out_q.size() - o0 < n) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        to = (cyc >= 4000);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; n_words = '0; ready_mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({read_start, read_addr, read_cnt, instr_valid, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b/%h/%0d/%b/%b/%b want all zero",
                     read_start, read_addr, read_cnt, instr_valid, busy, done);
        end
        n_cmp++;
        if (instr !== '0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, instr_valid, read_start} !== 3'b000) begin
            n_err++; $display("FAIL reset_release: got %b want 000", {busy, instr_valid, read_start});
        end
    endtask

    task automatic test_basic();
        int o0 = out_q.size(); int i0 = iss_a.size(); int d0 = done_cnt; bit to;
        ready_mode = 1;
        model_fetch(32'h0000_1000, 20);
        pulse_start(32'h0000_1000, 20);
        wait_fetch(o0, 20, d0, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout: got timeout want completion"); end
        n_cmp++;
        if (iss_a.size() - i0 != 3) begin n_err++; $display("FAIL basic_nbursts: got %0d want 3", iss_a.size() - i0); end
        for (int k = 0; k < exp_a.size() && i0 + k < iss_a.size(); k++) begin
            n_cmp++;
            if (iss_a[i0+k] !== exp_a[k] || iss_c[i0+k] != exp_c[k]) begin
                n_err++; $display("FAIL basic_burst%0d: got %h/%0d want %h/%0d", k, iss_a[i0+k], iss_c[i0+k], exp_a[k], exp_c[k]);
            end
        end
        n_cmp++;
        if (out_q.size() - o0 != 20) begin n_err++; $display("FAIL basic_nwords: got %0d want 20", out_q.size() - o0); end
        for (int k = 0; k < 20 && o0 + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[o0+k] !== exp_w[k]) begin n_err++; $display("FAIL basic_word%0d: got %h want %h", k, out_q[o0+k], exp_w[k]); end
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
    endtask

    task automatic test_zero_len();
        int i0 = iss_a.size(); int d0 = done_cnt; int b0 = busy_cyc;
        pulse_start(32'h0000_2000, 0);
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done_timing: got %b want 1", done); end
        repeat (4) @(negedge clk);
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (iss_a.size() != i0) begin n_err++; $display("FAIL zero_bursts: got %0d want 0", iss_a.size() - i0); end
        n_cmp++; if (busy_cyc != b0) begin n_err++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cyc - b0); end
    endtask

    task automatic test_back_pressure();
        int o0 = out_q.size(); int i0 = iss_a.size(); int d0 = done_cnt; int cyc = 0; bit to;
        ready_mode = 0;
        model_fetch(32'h0000_4000, 64);
        pulse_start(32'h0000_4000, 64);
        while (iss_a.size() - i0 < 4 && cyc < 1000) begin @(negedge clk); cyc++; end
        repeat (60) @(negedge clk);
        n_cmp++; if (iss_a.size() - i0 != 4) begin n_err++; $display("FAIL bp_stall_bursts: got %0d want 4", iss_a.size() - i0); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", instr_valid); end
        n_cmp++; if (out_q.size() != o0) begin n_err++; $display("FAIL bp_no_pop: got %0d want 0", out_q.size() - o0); end
        ready_mode = 1;
        wait_fetch(o0, 64, d0, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout: got timeout want completion"); end
        n_cmp++; if (iss_a.size() - i0 != 8) begin n_err++; $display("FAIL bp_nbursts: got %0d want 8", iss_a.size() - i0); end
        for (int k = 0; k < exp_a.size() && i0 + k < iss_a.size(); k++) begin
            n_cmp++;
            if (iss_a[i0+k] !== exp_a[k] || iss_c[i0+k] != exp_c[k]) begin
                n_err++; $display("FAIL bp_burst%0d: got %h/%0d want %h/%0d", k, iss_a[i0+k], iss_c[i0+k], exp_a[k], exp_c[k]);
            end
        end
        n_cmp++; if (out_q.size() - o0 != 64) begin n_err++; $display("FAIL bp_nwords: got %0d want 64", out_q.size() - o0); end
        for (int k = 0; k < 64 && o0 + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[o0+k] !== exp_w[k]) begin n_err++; $display("FAIL bp_word%0d: got %h want %h", k, out_q[o0+k], exp_w[k]); end
        end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL bp_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        int o0 = out_q.size(); int i0 = iss_a.size(); int d0 = done_cnt; int b0 = beats_sent; int cyc = 0; bit to;
        ready_mode = 0;
        pulse_start(32'h0000_8000, 16);
        while (beats_sent - b0 < 3 && cyc < 500) begin @(negedge clk); cyc++; end
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL abort_pre_valid: got %b want 1", instr_valid); end
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL abort_flush: got %b want 0", instr_valid); end
        cyc = 0;
        while (busy && cyc < 500) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got busy %b want 0", busy); end
        n_cmp++; if (beats_sent - b0 != 8) begin n_err++; $display("FAIL abort_beats: got %0d want 8", beats_sent - b0); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL abort_dropped: got %b want 0", instr_valid); end
        n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL abort_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (iss_a.size() - i0 != 1) begin n_err++; $display("FAIL abort_bursts: got %0d want 1", iss_a.size() - i0); end
        o0 = out_q.size(); d0 = done_cnt;
        ready_mode = 1;
        model_fetch(32'h0000_9000, 12);
        pulse_start(32'h0000_9000, 12);
        wait_fetch(o0, 12, d0, to);
        n_cmp++; if (to || out_q.size() - o0 != 12) begin n_err++; $display("FAIL abort_refetch_n: got %0d want 12", out_q.size() - o0); end
        for (int k = 0; k < 12 && o0 + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[o0+k] !== exp_w[k]) begin n_err++; $display("FAIL abort_refetch%0d: got %h want %h", k, out_q[o0+k], exp_w[k]); end
        end
    endtask

    task automatic test_wrap();
        int o0 = out_q.size(); int i0 = iss_a.size(); int d0 = done_cnt; bit to;
        ready_mode = 1;
        model_fetch(32'hFFFF_FF80, 16);
        pulse_start(32'hFFFF_FF80, 16);
        wait_fetch(o0, 16, d0, to);
        n_cmp++; if (to || iss_a.size() - i0 != 2) begin n_err++; $display("FAIL wrap_nbursts: got %0d want 2", iss_a.size() - i0); end
        if (iss_a.size() - i0 >= 2) begin
            n_cmp++;
            if (iss_a[i0+1] !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_addr: got %h want 00000000", iss_a[i0+1]); end
        end
        n_cmp++; if (out_q.size() - o0 != 16) begin n_err++; $display("FAIL wrap_nwords: got %0d want 16", out_q.size() - o0); end
        for (int k = 0; k < 16 && o0 + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[o0+k] !== exp_w[k]) begin n_err++; $display("FAIL wrap_word%0d: got %h want %h", k, out_q[o0+k], exp_w[k]); end
        end
    endtask

    task automatic test_reset_busy();
        int o0 = out_q.size(); int i0 = iss_a.size(); int d0 = done_cnt; int b0; int cyc = 0; bit to;
        ready_mode = 1;
        model_fetch(32'h0000_3000, 20);
        pulse_start(32'h0000_3000, 20);
        while (iss_a.size() == i0 && cyc < 200) begin @(negedge clk); cyc++; end
        pulse_start(32'h0000_7000, 5);
        wait_fetch(o0, 20, d0, to);
        n_cmp++; if (to || done_cnt - d0 != 1) begin n_err++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (iss_a.size() - i0 != exp_a.size()) begin n_err++; $display("FAIL busy_start_bursts: got %0d want %0d", iss_a.size() - i0, exp_a.size()); end
        for (int k = 0; k < 20 && o0 + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[o0+k] !== exp_w[k]) begin n_err++; $display("FAIL busy_start_word%0d: got %h want %h", k, out_q[o0+k], exp_w[k]); end
        end
        b0 = beats_sent; cyc = 0;
        pulse_start(32'h0000_5000, 24);
        while (beats_sent - b0 < 2 && cyc < 200) begin @(negedge clk); cyc++; end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({read_start, read_addr, read_cnt, instr_valid, busy, done} !== '0 || instr !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b/%h/%0d/%b/%b/%b want all zero",
                     read_start, read_addr, read_cnt, instr_valid, busy, done);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_idle: got busy %b want 0", busy); end
        o0 = out_q.size(); d0 = done_cnt;
        model_fetch(32'h0000_6000, 10);
        pulse_start(32'h0000_6000, 10);
        wait_fetch(o0, 10, d0, to);
        n_cmp++; if (to || out_q.size() - o0 != 10) begin n_err++; $display("FAIL midreset_refetch_n: got %0d want 10", out_q.size() - o0); end
        for (int k = 0; k < 10 && o0 + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[o0+k] !== exp_w[k]) begin n_err++; $display("FAIL midreset_word%0d: got %h want %h", k, out_q[o0+k], exp_w[k]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int o0 = out_q.size(); int i0 = iss_a.size(); int d0 = done_cnt; bit to;
            int n = int'($urandom_range(1, 48));
            logic [ADDR_W-1:0] base = $urandom() & 32'hFFFF_FFF0;
            ready_mode = 2;
            model_fetch(base, n);
            pulse_start(base, n);
            wait_fetch(o0, n, d0, to);
            n_cmp++; if (to || done_cnt - d0 != 1) begin n_err++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt - d0); end
            n_cmp++; if (iss_a.size() - i0 != exp_a.size()) begin n_err++; $display("FAIL rand%0d_nbursts: got %0d want %0d", it, iss_a.size() - i0, exp_a.size()); end
            for (int k = 0; k < exp_a.size() && i0 + k < iss_a.size(); k++) begin
                n_cmp++;
                if (iss_a[i0+k] !== exp_a[k] || iss_c[i0+k] != exp_c[k]) begin
                    n_err++; $display("FAIL rand%0d_burst%0d: got %h/%0d want %h/%0d", it, k, iss_a[i0+k], iss_c[i0+k], exp_a[k], exp_c[k]);
                end
            end
            n_cmp++; if (out_q.size() - o0 != n) begin n_err++; $display("FAIL rand%0d_nwords: got %0d want %0d", it, out_q.size() - o0, n); end
            for (int k = 0; k < n && o0 + k < out_q.size(); k++) begin
                n_cmp++;
                if (out_q[o0+k] !== exp_w[k]) begin n_err++; $display("FAIL rand%0d_word%0d: got %h want %h", it, k, out_q[o0+k], exp_w[k]); end
            end
        end
        n_cmp++; if (pulse_err != 0) begin n_err++; $display("FAIL read_start_width: got %0d long pulses want 0", pulse_err); end
        n_cmp++; if (hold_err != 0) begin n_err++; $display("FAIL read_addr_hold: got %0d changes want 0", hold_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_back_pressure();
        test_abort();
        test_wrap();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
